secuenciador_bebida: RTL and testbench

SECUENCIADOR_BEBIDA -- requirements
Module: secuenciador_bebida

---
 rtl/secuenciador_bebida.sv | 173 +++++++++++++++++
 tb/tb_secuenciador_bebida.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/secuenciador_bebida.sv
// Drink-dispenser sequencer: validates credit, then steps through the ingredient valves paced by tick_1hz.
// Optional sugar step is compiled in when the AZUCAR_EN macro is defined.
module secuenciador_bebida (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic [1:0] sel,
  input  logic [7:0] credito,
  input  logic       azucar_req,
  output logic       agua,
  output logic       cafe,
  output logic       leche,
  output logic       choco,
  output logic       azucar,
  output logic       bebida_lista,
  output logic       error_monto,
  output logic [7:0] vuelto,
  output logic       ocupado,
  output logic [3:0] estado
);

`ifdef AZUCAR_EN
  localparam logic AZ_ON = 1'b1;
`else
  localparam logic AZ_ON = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CHECK   = 4'd1,
    S_AGUA    = 4'd2,
    S_CAFE    = 4'd3,
    S_LECHE   = 4'd4,
    S_CHOCO   = 4'd5,
    S_AZUCAR  = 4'd6,
    S_LISTO   = 4'd7,
    S_RECHAZO = 4'd8
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [1:0] sel_q;
  logic [7:0] cred_q;
  logic       az_q;
  logic [1:0] cnt;
  logic       azucar_r;
  logic       adv;
  logic       reject;

  function automatic logic [7:0] price(input logic [1:0] s);
    case (s)
      2'd0:    price = 8'd3;
      2'd1:    price = 8'd4;
      2'd2:    price = 8'd5;
      default: price = 8'd7;
    endcase
  endfunction

  // Duration in ticks of each timed state for the latched drink; zero means the step is skipped.
  function automatic logic [1:0] dur(input state_t st, input logic [1:0] s, input logic az);
    logic [1:0] d;
    d = 2'd0;
    case (st)
      S_AGUA: case (s)
        2'd0: d = 2'd2;
        2'd1: d = 2'd2;
        2'd2: d = 2'd1;
        default: d = 2'd3;
      endcase
      S_CAFE: case (s)
        2'd0: d = 2'd3;
        2'd1: d = 2'd2;
        2'd2: d = 2'd2;
        default: d = 2'd0;
      endcase
      S_LECHE: case (s)
        2'd0: d = 2'd0;
        2'd1: d = 2'd3;
        2'd2: d = 2'd3;
        default: d = 2'd2;
      endcase
      S_CHOCO: case (s)
        2'd2: d = 2'd1;
        2'd3: d = 2'd3;
        default: d = 2'd0;
      endcase
      S_AZUCAR:  d = {1'b0, az & AZ_ON};
      S_LISTO:   d = 2'd3;
      S_RECHAZO: d = 2'd2;
      default:   d = 2'd0;
    endcase
    return d;
  endfunction

  // First ingredient step at or after 'from' with a nonzero duration, else LISTO.
  function automatic state_t first_from(input logic [3:0] from, input logic [1:0] s, input logic az);
    state_t r;
    logic [3:0] c;
    r = S_LISTO;
    for (int i = 6; i >= 2; i--) begin
      c = 4'(i);
      if (c >= from && dur(state_t'(c), s, az) != 2'd0)
        r = state_t'(c);
    end
    return r;
  endfunction

  assign adv    = tick_1hz && ({1'b0, cnt} + 3'd1 == {1'b0, dur(state, sel_q, az_q)});
  assign reject = (cred_q < price(sel_q)) || (cred_q >= 8'd11);

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (start) nxt = S_CHECK;
      S_CHECK:   nxt = reject ? S_RECHAZO : first_from(4'd2, sel_q, az_q);
      S_AGUA, S_CAFE, S_LECHE, S_CHOCO, S_AZUCAR:
        if (adv) nxt = first_from(4'(state) + 4'd1, sel_q, az_q);
      S_LISTO, S_RECHAZO:
        if (adv) nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      sel_q        <= 2'd0;
      cred_q       <= 8'd0;
      az_q         <= 1'b0;
      cnt          <= 2'd0;
      agua         <= 1'b0;
      cafe         <= 1'b0;
      leche        <= 1'b0;
      choco        <= 1'b0;
      azucar_r     <= 1'b0;
      bebida_lista <= 1'b0;
      error_monto  <= 1'b0;
      vuelto       <= 8'd0;
      ocupado      <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && start) begin
        sel_q  <= sel;
        cred_q <= credito;
        az_q   <= azucar_req & AZ_ON;
      end
      if (nxt != state)
        cnt <= 2'd0;
      else if (tick_1hz && state >= S_AGUA)
        cnt <= cnt + 2'd1;
      agua         <= (nxt == S_AGUA);
      cafe         <= (nxt == S_CAFE);
      leche        <= (nxt == S_LECHE);
      choco        <= (nxt == S_CHOCO);
      azucar_r     <= (nxt == S_AZUCAR);
      bebida_lista <= (nxt == S_LISTO);
      error_monto  <= (nxt == S_RECHAZO);
      ocupado      <= (nxt != S_IDLE);
      if (nxt == S_LISTO)
        vuelto <= cred_q - price(sel_q);
      else if (nxt == S_RECHAZO)
        vuelto <= cred_q;
      else
        vuelto <= 8'd0;
    end
  end

  assign azucar = azucar_r & AZ_ON;
  assign estado = state;

endmodule

// File: tb/tb_secuenciador_bebida.sv
// Self-checking bench for secuenciador_bebida: directed drinks plus randomized drinks against a recipe-table model.
module tb_secuenciador_bebida;

`ifdef AZUCAR_EN
  localparam bit AZ = 1'b1;
`else
  localparam bit AZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, tick_1hz, start, azucar_req;
  logic [1:0] sel;
  logic [7:0] credito;
  logic       agua, cafe, leche, choco, azucar, bebida_lista, error_monto, ocupado;
  logic [7:0] vuelto;
  logic [3:0] estado;

  int checks = 0;
  int errors = 0;

  typedef struct { int code; int dur; } seg_t;

  always #5 clk = ~clk;

  secuenciador_bebida dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .start(start), .sel(sel),
    .credito(credito), .azucar_req(azucar_req), .agua(agua), .cafe(cafe),
    .leche(leche), .choco(choco), .azucar(azucar), .bebida_lista(bebida_lista),
    .error_monto(error_monto), .vuelto(vuelto), .ocupado(ocupado), .estado(estado)
  );

  function automatic int price_of(input int s);
    int p[4] = '{3, 4, 5, 7};
    return p[s];
  endfunction

  // Recipe table: ticks of agua, cafe, leche, choco per drink.
  function automatic int recipe(input int s, input int step);
    int t[4][4] = '{'{2, 3, 0, 0}, '{2, 2, 3, 0}, '{1, 2, 3, 1}, '{3, 0, 2, 3}};
    return t[s][step];
  endfunction

  // Expected output bundle {valves[5], lista, error, ocupado, vuelto[8], estado[4]} for a state code.
  function automatic logic [19:0] exp_vec(input int code, input int cred, input int pr);
    logic [4:0] valves;
    logic [7:0] v;
    valves = (code >= 2 && code <= 6) ? 5'(1 << (6 - code)) : 5'd0;
    v = (code == 7) ? 8'(cred - pr) : (code == 8) ? 8'(cred) : 8'd0;
    return {valves, code == 7, code == 8, code != 0, v, 4'(code)};
  endfunction

  function automatic logic [19:0] obs_vec();
    return {agua, cafe, leche, choco, azucar, bebida_lista, error_monto, ocupado, vuelto, estado};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs one drink; noise perturbs inputs mid-drink, abort_code pulls reset on entry to that state.
  task automatic run_drink(input int s, input int c, input bit a, input bit noise,
                           input int abort_code, input string tag);
    seg_t segs[$];
    int pr, cur, nextc, gap;
    pr = price_of(s);
    if (c < pr || c >= 11) segs.push_back('{8, 2});
    else begin
      for (int k = 0; k < 4; k++)
        if (recipe(s, k) != 0) segs.push_back('{k + 2, recipe(s, k)});
      if (AZ && a) segs.push_back('{6, 1});
      segs.push_back('{7, 3});
    end
    sel = 2'(s); credito = 8'(c); azucar_req = a; start = 1'b1; tick_1hz = 1'($urandom);
    cyc();
    start = 1'b0; tick_1hz = 1'b0;
    chk({tag, " check"}, 32'(obs_vec()), 32'(exp_vec(1, c, pr)));
    if (noise) begin credito = 8'($urandom); sel = 2'($urandom); azucar_req = 1'($urandom); end
    tick_1hz = 1'($urandom);
    cyc();
    tick_1hz = 1'b0;
    for (int idx = 0; idx < segs.size(); idx++) begin
      cur = segs[idx].code;
      chk({tag, " entry"}, 32'(obs_vec()), 32'(exp_vec(cur, c, pr)));
      if (cur == abort_code) begin
        rst = 1'b0;
        #2;
        chk({tag, " async rst"}, 32'(obs_vec()), 32'd0);
        cyc();
        rst = 1'b1;
        cyc();
        chk({tag, " after rst"}, 32'(obs_vec()), 32'd0);
        return;
      end
      for (int k = 1; k <= segs[idx].dur; k++) begin
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          if (noise) begin start = 1'($urandom); credito = 8'($urandom); end
          cyc();
          start = 1'b0;
          chk({tag, " hold"}, 32'(obs_vec()), 32'(exp_vec(cur, c, pr)));
        end
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        nextc = (k < segs[idx].dur) ? cur : (idx + 1 < segs.size()) ? segs[idx + 1].code : 0;
        chk({tag, " tick"}, 32'(obs_vec()), 32'(exp_vec(nextc, c, pr)));
      end
    end
  endtask

  initial begin
    rst = 1'b0; tick_1hz = 1'b0; start = 1'b0; sel = 2'd0; credito = 8'd0; azucar_req = 1'b0;
    #1;
    chk("reset async", 32'(obs_vec()), 32'd0);
    repeat (2) cyc();
    chk("reset held", 32'(obs_vec()), 32'd0);
    rst = 1'b1;
    cyc();
    chk("idle", 32'(obs_vec()), 32'd0);

    run_drink(0, 5, 1'b1, 1'b0, -1, "expreso");
    run_drink(3, 7, 1'b0, 1'b0, -1, "chocolate");
    run_drink(2, 4, 1'b0, 1'b0, -1, "capu low");
    run_drink(2, 11, 1'b0, 1'b0, -1, "capu high");
    run_drink(1, 6, 1'b0, 1'b1, -1, "leche noise");
    run_drink(1, 6, 1'b0, 1'b0, 4, "leche abort");
    run_drink(2, 5, 1'b1, 1'b0, -1, "after abort");
    run_drink(0, 3, 1'b1, 1'b0, -1, "expreso exact");
    run_drink(3, 10, 1'b1, 1'b0, -1, "choco max");
    run_drink(0, 255, 1'b0, 1'b0, -1, "credit 255");
    run_drink(3, 0, 1'b0, 1'b0, -1, "credit 0");

    for (int n = 0; n < 25; n++)
      run_drink($urandom_range(0, 3), $urandom_range(0, 13), 1'($urandom), 1'b1, -1, "random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
